bht_local_param: RTL and testbench

Parametrised local-history branch predictor for the inst_buffer second-level prediction stage. Supports NUM_PORTS lookup ports and configurable history length, table depths and counter width. Tables are trained from the ex stage through a registered update pipe with same-entry forwarding. After reset, a sweep FSM initialises every table entry, replacing the valid-bit arrays of the previous generation.

---
 rtl/bht_pkg.sv | 16 +
 rtl/bht_sat_ctr.sv | 19 +
 rtl/bht_local_param.sv | 129 ++++++++++++
 tb/tb_bht_local_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared types and constants for the local-history branch predictor.
package bht_pkg;

  localparam logic [1:0] BT_NO     = 2'b00;
  localparam logic [1:0] BT_BRANCH = 2'b01;
  localparam logic [1:0] BT_RET    = 2'b10;
  localparam logic [1:0] BT_J      = 2'b11;

  typedef enum logic {INIT, RUN} bht_state_e;

  // Weakly-not-taken value: just below the MSB-set threshold.
  function automatic int unsigned ctr_init(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bht_sat_ctr.sv
// Next-state logic of a saturating up/down counter.
module bht_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  output logic [CTR_W-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != '1) ctr_next = ctr + CTR_W'(1);
    end else begin
      if (ctr != '0) ctr_next = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/bht_local_param.sv
// Local-history branch predictor: per-PC history (BHT) indexes a table of
// saturating counters (PHT); trained through a one-entry write pipe with forwarding.
module bht_local_param
  import bht_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int BHT_IDX_W = 8,
  parameter int HIST_W    = 4,
  parameter int PHT_IDX_W = 10,
  parameter int CTR_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [32*NUM_PORTS-1:0] pred_addr_i,
  input  logic [2*NUM_PORTS-1:0]  pred_type_i,
  output logic [NUM_PORTS-1:0]    predict_o,
  output logic                   ready_o,
  input  logic [1:0]             ex_branch_type_i,
  input  logic [31:0]            ex_inst_addr_i,
  input  logic                   ex_branch_success_i
);

  localparam int BHT_D = 1 << BHT_IDX_W;
  localparam int PHT_D = 1 << PHT_IDX_W;
  localparam int SW    = (BHT_IDX_W > PHT_IDX_W) ? BHT_IDX_W : PHT_IDX_W;
  localparam int LOW_W = PHT_IDX_W - HIST_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

  bht_state_e state, state_next;
  logic [SW-1:0] sweep;

  logic [HIST_W-1:0] bht_hist [BHT_D];
  logic [CTR_W-1:0]  pht_ctr  [PHT_D];

  logic                 p_valid;
  logic [BHT_IDX_W-1:0] p_bi;
  logic [PHT_IDX_W-1:0] p_pi;
  logic [HIST_W-1:0]    p_hist;
  logic [CTR_W-1:0]     p_ctr;

  // Only a slice of each PC feeds the indices.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pred_addr_i, ex_inst_addr_i};

  assign ready_o = (state == RUN);

  // Lookup ports; the pending pipe entry overrides stale array contents.
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic [BHT_IDX_W-1:0] bi;
    logic [HIST_W-1:0]    hist;
    logic [PHT_IDX_W-1:0] pi;
    logic [CTR_W-1:0]     ctr;
    assign bi   = pred_addr_i[32*k+2 +: BHT_IDX_W];
    assign hist = (p_valid && p_bi == bi) ? p_hist : bht_hist[bi];
    assign pi   = {hist, pred_addr_i[32*k+2 +: LOW_W]};
    assign ctr  = (p_valid && p_pi == pi) ? p_ctr : pht_ctr[pi];
    assign predict_o[k] = (state == RUN) && (pred_type_i[2*k +: 2] == BT_BRANCH)
                          && ctr[CTR_W-1];
  end

  // U0: read with the same forwarding as the lookup ports.
  logic [BHT_IDX_W-1:0] ex_bi;
  logic [HIST_W-1:0]    ex_hist, ex_hist_new;
  logic [PHT_IDX_W-1:0] ex_pi;
  logic [CTR_W-1:0]     ex_ctr, ex_ctr_new;
  logic                 ex_upd;

  assign ex_bi       = ex_inst_addr_i[BHT_IDX_W+1:2];
  assign ex_hist     = (p_valid && p_bi == ex_bi) ? p_hist : bht_hist[ex_bi];
  assign ex_pi       = {ex_hist, ex_inst_addr_i[LOW_W+1:2]};
  assign ex_ctr      = (p_valid && p_pi == ex_pi) ? p_ctr : pht_ctr[ex_pi];
  assign ex_hist_new = HIST_W'({ex_hist, ex_branch_success_i});
  assign ex_upd      = (state == RUN) && (ex_branch_type_i == BT_BRANCH);

  bht_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr      (ex_ctr),
    .inc      (ex_branch_success_i),
    .ctr_next (ex_ctr_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) sweep <= sweep + SW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (sweep == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_bi    <= '0;
      p_pi    <= '0;
      p_hist  <= '0;
      p_ctr   <= '0;
    end else begin
      p_valid <= ex_upd;
      p_bi    <= ex_bi;
      p_pi    <= ex_pi;
      p_hist  <= ex_hist_new;
      p_ctr   <= ex_ctr_new;
    end
  end

  // Single write port per table: sweep address while initialising, pipe entry after.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        if ((sweep >> BHT_IDX_W) == '0) bht_hist[sweep[BHT_IDX_W-1:0]] <= '0;
        if ((sweep >> PHT_IDX_W) == '0) pht_ctr[sweep[PHT_IDX_W-1:0]] <= CTR_INIT;
      end else if (p_valid) begin
        bht_hist[p_bi] <= p_hist;
        pht_ctr[p_pi]  <= p_ctr;
      end
    end
  end

endmodule

// File: tb/tb_bht_local_param.sv
// Directed and random checks of bht_local_param against a table model,
// using a 2-bit-counter and a 3-bit-counter instance driven in lockstep.
module tb_bht_local_param;
  import bht_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pred_addr;
  logic [3:0]  pred_type;
  logic [1:0]  predict_a, predict_b;
  logic        ready_a, ready_b;
  logic [1:0]  ex_type;
  logic [31:0] ex_addr;
  logic        ex_succ;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  logic [3:0] m_hist [256];
  logic [1:0] m_c2   [1024];
  logic [2:0] m_c3   [1024];

  // clock / reset
  always #5 clk = ~clk;

  bht_local_param dut_a (
    .clk(clk), .rst(rst), .pred_addr_i(pred_addr), .pred_type_i(pred_type),
    .predict_o(predict_a), .ready_o(ready_a), .ex_branch_type_i(ex_type),
    .ex_inst_addr_i(ex_addr), .ex_branch_success_i(ex_succ)
  );

  bht_local_param #(.CTR_W(3)) dut_b (
    .clk(clk), .rst(rst), .pred_addr_i(pred_addr), .pred_type_i(pred_type),
    .predict_o(predict_b), .ready_o(ready_b), .ex_branch_type_i(ex_type),
    .ex_inst_addr_i(ex_addr), .ex_branch_success_i(ex_succ)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 256; i++) m_hist[i] = 4'b0000;
    for (int i = 0; i < 1024; i++) begin
      m_c2[i] = 2'd1;
      m_c3[i] = 3'd3;
    end
  endtask

  function automatic logic exp_pred(input logic [31:0] a, input logic [1:0] t, input bit wide);
    logic [3:0] h;
    logic [9:0] pi;
    h  = m_hist[a[9:2]];
    pi = {h, a[7:2]};
    return (t == BT_BRANCH) && (wide ? m_c3[pi][2] : m_c2[pi][1]);
  endfunction

  task automatic model_update(input logic [31:0] a, input logic tk);
    logic [3:0] h;
    logic [9:0] pi;
    h  = m_hist[a[9:2]];
    pi = {h, a[7:2]};
    if (tk) begin
      if (m_c2[pi] != 2'd3) m_c2[pi] = m_c2[pi] + 2'd1;
      if (m_c3[pi] != 3'd7) m_c3[pi] = m_c3[pi] + 3'd1;
    end else begin
      if (m_c2[pi] != 2'd0) m_c2[pi] = m_c2[pi] - 2'd1;
      if (m_c3[pi] != 3'd0) m_c3[pi] = m_c3[pi] - 3'd1;
    end
    m_hist[a[9:2]] = {h[2:0], tk};
  endtask

  // One cycle: entered and left just after a rising edge.
  task automatic step(input string tag, input logic [31:0] a0, input logic [1:0] t0,
                      input logic [31:0] a1, input logic [1:0] t1,
                      input logic [1:0] et, input logic [31:0] ea, input logic tk);
    logic [3:0] exp;
    pred_addr = {a1, a0};
    pred_type = {t1, t0};
    ex_type   = et;
    ex_addr   = ea;
    ex_succ   = tk;
    exp_q.push_back({exp_pred(a1, t1, 1'b1), exp_pred(a0, t0, 1'b1),
                     exp_pred(a1, t1, 1'b0), exp_pred(a0, t0, 1'b0)});
    @(negedge clk);
    exp = exp_q.pop_front();
    chk(tag, {28'd0, predict_b, predict_a}, {28'd0, exp});
    @(posedge clk);
    #1;
    if (et == BT_BRANCH) model_update(ea, tk);
    ex_type = BT_NO;
  endtask

  // Release reset and measure the sweep; branch updates near the end must be dropped.
  task automatic do_sweep(input string tag);
    int n;
    n = 0;
    rst = 1'b0;
    pred_addr = {32'h40, 32'h100};
    pred_type = {BT_BRANCH, BT_BRANCH};
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (n >= 1000 && n < 1010) begin
        ex_type = BT_BRANCH; ex_addr = 32'h40; ex_succ = 1'b1;
      end else begin
        ex_type = BT_NO;
      end
      if (ready_a) break;
      if (n == 1 || n == 600) begin
        chk({tag, "_init_pred"}, {28'd0, predict_b, predict_a}, 32'd0);
        chk({tag, "_init_ready"}, {30'd0, ready_b, ready_a}, 32'd0);
      end
    end
    ex_type = BT_NO;
    chk({tag, "_latency"}, n, 32'd1024);
    chk({tag, "_ready"}, {30'd0, ready_b, ready_a}, 32'd3);
  endtask

  logic [31:0] pcs [6];

  initial begin
    pcs = '{32'h40, 32'h80, 32'h100, 32'h200, 32'h440, 32'h3c4};
    rst = 1'b1;
    pred_addr = '0;
    pred_type = {BT_BRANCH, BT_BRANCH};
    ex_type = BT_NO;
    ex_addr = '0;
    ex_succ = 1'b0;
    model_init();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {30'd0, ready_b, ready_a}, 32'd0);
    chk("reset_pred", {28'd0, predict_b, predict_a}, 32'd0);

    do_sweep("sweep1");

    step("post_init", 32'h40, BT_BRANCH, 32'h80, BT_BRANCH, BT_NO, 32'h0, 1'b0);

    // First taken update of 0x40, then repeated taken updates back to back.
    step("same_cycle", 32'h40, BT_BRANCH, 32'h40, BT_BRANCH, BT_BRANCH, 32'h40, 1'b1);
    step("fwd_next", 32'h40, BT_BRANCH, 32'h40, BT_BRANCH, BT_NO, 32'h0, 1'b0);
    for (int i = 0; i < 7; i++)
      step("train_40", 32'h40, BT_BRANCH, 32'h40, BT_BRANCH, BT_BRANCH, 32'h40, 1'b1);
    step("trained_40", 32'h40, BT_BRANCH, 32'h440, BT_BRANCH, BT_NO, 32'h0, 1'b0);
    step("array_40", 32'h40, BT_BRANCH, 32'h40, BT_RET, BT_NO, 32'h0, 1'b0);

    // History walk on 0x80: train pass, then replay exposing each history step.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++)
        step(p == 0 ? "hist_pass1" : "hist_pass2", 32'h80, BT_BRANCH, 32'h40, BT_BRANCH,
             BT_BRANCH, 32'h80, (i < 4));

    // Saturation on 0x200: cap visible on the 3-bit instance.
    for (int i = 0; i < 10; i++)
      step("sat_up", 32'h200, BT_BRANCH, 32'h200, BT_BRANCH, BT_BRANCH, 32'h200, 1'b1);
    step("sat_top", 32'h200, BT_BRANCH, 32'h200, BT_BRANCH, BT_NO, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      step("sat_down", 32'h200, BT_BRANCH, 32'h200, BT_BRANCH, BT_BRANCH, 32'h200, 1'b0);
    step("sat_bottom", 32'h200, BT_BRANCH, 32'h200, BT_BRANCH, BT_NO, 32'h0, 1'b0);

    // Port type gating on a trained-taken PC.
    for (int i = 0; i < 8; i++)
      step("train_100", 32'h100, BT_NO, 32'h100, BT_NO, BT_BRANCH, 32'h100, 1'b1);
    step("type_j", 32'h100, BT_BRANCH, 32'h100, BT_J, BT_NO, 32'h0, 1'b0);
    chk("type_j_direct", {30'd0, predict_a}, 32'd1);
    step("equal_idx", 32'h100, BT_BRANCH, 32'h100, BT_BRANCH, BT_J, 32'h100, 1'b0);

    for (int i = 0; i < 80; i++)
      step("random", pcs[$urandom_range(0, 5)], 2'($urandom_range(0, 3)),
           pcs[$urandom_range(0, 5)], 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));

    // Reset while an update is pending in the pipe.
    ex_type = BT_BRANCH; ex_addr = 32'h100; ex_succ = 1'b0;
    @(posedge clk);
    #1;
    ex_type = BT_NO;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready_drop", {30'd0, ready_b, ready_a}, 32'd0);
    model_init();
    do_sweep("sweep2");
    step("post_rst_100", 32'h100, BT_BRANCH, 32'h40, BT_BRANCH, BT_NO, 32'h0, 1'b0);
    step("post_rst_200", 32'h200, BT_BRANCH, 32'h80, BT_BRANCH, BT_BRANCH, 32'h100, 1'b1);
    step("post_rst_fwd", 32'h100, BT_BRANCH, 32'h100, BT_BRANCH, BT_NO, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
